// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, loads IF/ID, and applies stall/redirect/flush.
// Define FETCH_HALT_DETECT_EN to build the self-loop detector that parks the fetch stage.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ifid_pc_q, ifid_pc4_q, ifid_instr_q;
    logic        ifid_valid_q;
    logic [31:0] fetch_count_q;
    logic [31:0] pc_plus4;
    logic        capture, bubble, pc_adv;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_HALT_DETECT_EN
    logic self_loop;
    assign self_loop = ((imem_instr[31:26] == 6'b000010) &&
                        ({pc_q[31:28], imem_instr[25:0], 2'b00} == pc_q)) ||
                       (imem_instr == 32'h1000_FFFF);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef FETCH_HALT_DETECT_EN
        case (state_q)
            ST_RUN: begin
                if (!stall && !flush && self_loop) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!stall) begin
                    state_d = (flush || redirect) ? ST_RUN : ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
`else
        state_d = ST_RUN;
`endif
    end

    // A PEND cycle that is not cancelled already parks: PC holds and IF/ID gets a bubble.
    always_comb begin
        capture = 1'b0;
        bubble  = 1'b0;
        pc_adv  = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_HALT: begin
                bubble = 1'b1;
                halted = 1'b1;
            end
            ST_PEND: begin
                if (!stall) begin
                    if (flush) begin
                        bubble = 1'b1;
                    end else if (redirect) begin
                        capture = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                    pc_adv = flush || redirect;
                end
            end
            default: begin
                if (!stall) begin
                    if (flush) begin
                        bubble = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                    pc_adv = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'd0;
            ifid_pc4_q    <= 32'd0;
            ifid_instr_q  <= 32'd0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            if (pc_adv) begin
                pc_q <= redirect ? redirect_pc : pc_plus4;
            end
            if (capture) begin
                ifid_pc_q     <= pc_q;
                ifid_pc4_q    <= pc_plus4;
                ifid_instr_q  <= imem_instr;
                ifid_valid_q  <= 1'b1;
                fetch_count_q <= fetch_count_q + 32'd1;
            end else if (bubble) begin
                ifid_pc_q    <= 32'd0;
                ifid_pc4_q   <= 32'd0;
                ifid_instr_q <= 32'd0;
                ifid_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus randomized traffic against a ROM and
// a behavioural fetch model; covers both builds of FETCH_HALT_DETECT_EN.
module tb_instr_fetch_ctrl;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [0:255];

    int errors = 0;
    int checks = 0;

    // Behavioural model of the fetch stage
    logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_ifid_instr, m_count;
    logic        m_valid, m_pend, m_halted;

    instr_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_instr = rom[imem_addr[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_loop(input logic [31:0] w, input logic [31:0] a);
        return ((w[31:26] == 6'b000010) && ({a[31:28], w[25:0], 2'b00} == a)) ||
               (w == 32'h1000_FFFF);
    endfunction

    task automatic m_bubble();
        m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = 0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic rst_n, input logic st, input logic fl,
                              input logic rd, input logic [31:0] rpc);
        logic [31:0] w;
        w = rom[m_pc[9:2]];
        if (!rst_n) begin
            m_pc = 0; m_count = 0; m_pend = 0; m_halted = 0;
            m_bubble();
        end else if (m_halted) begin
            m_bubble();
        end else if (st) begin
            // everything holds
        end else if (m_pend && !fl && !rd) begin
            m_halted = 1'b1;
            m_pend = 1'b0;
            m_bubble();
        end else begin
            if (fl) begin
                m_bubble();
            end else begin
                m_ifid_pc = m_pc; m_ifid_pc4 = m_pc + 32'd4; m_ifid_instr = w;
                m_valid = 1'b1; m_count = m_count + 32'd1;
            end
            m_pend = !m_pend && !fl && HALT_EN && is_loop(w, m_pc);
            m_pc = rd ? rpc : m_pc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then return on the falling edge.
    task automatic cycle(input logic rst_n, input logic st, input logic fl,
                         input logic rd, input logic [31:0] rpc);
        reset = rst_n; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        model_step(rst_n, st, fl, rd, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
        checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h/%h expected zeros", ifid_pc, ifid_pc4, ifid_instr); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (ifid_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, ifid_pc, 32'(4 * i)); end
            checks++; if (ifid_pc4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL seq_pc4[%0d]: got %h expected %h", i, ifid_pc4, 32'(4 * i + 4)); end
            checks++; if (ifid_instr !== rom[i] || ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_instr[%0d]: got %h v=%b expected %h v=1", i, ifid_instr, ifid_valid, rom[i]); end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h10 || ifid_pc !== 32'hC || ifid_instr !== rom[3] || fetch_count !== 32'd4) begin
            errors++; $display("FAIL stall1: got addr=%h pc=%h instr=%h cnt=%0d expected 10/c/%h/4", imem_addr, ifid_pc, ifid_instr, fetch_count, rom[3]); end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        checks++; if (imem_addr !== 32'h10 || ifid_pc !== 32'hC || ifid_valid !== 1'b1 || fetch_count !== 32'd4) begin
            errors++; $display("FAIL stall2_flush: got addr=%h pc=%h v=%b cnt=%0d expected 10/c/1/4", imem_addr, ifid_pc, ifid_valid, fetch_count); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h14 || ifid_pc !== 32'h10 || fetch_count !== 32'd5) begin
            errors++; $display("FAIL stall_resume: got addr=%h pc=%h cnt=%0d expected 14/10/5", imem_addr, ifid_pc, fetch_count); end
    endtask

    task automatic test_redirect();
        for (int k = 0; k < 64 && m_pc != 32'h3C; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (ifid_pc !== 32'h38 || imem_addr !== 32'h3C) begin errors++; $display("FAIL redir_setup: got pc=%h addr=%h expected 38/3c", ifid_pc, imem_addr); end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h48);
        checks++; if (ifid_pc !== 32'h3C || ifid_valid !== 1'b1 || imem_addr !== 32'h48) begin
            errors++; $display("FAIL redir_delay_slot: got pc=%h v=%b addr=%h expected 3c/1/48", ifid_pc, ifid_valid, imem_addr); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (ifid_pc !== 32'h48 || ifid_instr !== rom[18]) begin
            errors++; $display("FAIL redir_target: got pc=%h instr=%h expected 48/%h", ifid_pc, ifid_instr, rom[18]); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        cnt_before = m_count;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL flush_bubble: got v=%b instr=%h expected 0/0", ifid_valid, ifid_instr); end
        checks++; if (imem_addr !== 32'h50) begin errors++; $display("FAIL flush_pc: got %h expected 50", imem_addr); end
        checks++; if (fetch_count !== cnt_before) begin errors++; $display("FAIL flush_count: got %0d expected %0d", fetch_count, cnt_before); end
    endtask

    task automatic test_halt();
        logic [31:0] exp_addr;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (ifid_pc !== 32'h40 || ifid_instr !== 32'h0800_0010 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_capture: got pc=%h instr=%h h=%b expected 40/08000010/0", ifid_pc, ifid_instr, halted); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_addr = HALT_EN ? 32'h44 : 32'h48;
        checks++; if (halted !== HALT_EN) begin errors++; $display("FAIL halt_flag: got %b expected %b", halted, HALT_EN); end
        checks++; if (imem_addr !== exp_addr || ifid_valid !== !HALT_EN) begin
            errors++; $display("FAIL halt_park: got addr=%h v=%b expected %h/%b", imem_addr, ifid_valid, exp_addr, !HALT_EN); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 32'h100);
            checks++; if (imem_addr !== m_pc || ifid_valid !== m_valid || fetch_count !== m_count || halted !== m_halted) begin
                errors++; $display("FAIL halt_hold[%0d]: got addr=%h v=%b cnt=%0d h=%b expected %h/%b/%0d/%b",
                                   i, imem_addr, ifid_valid, fetch_count, halted, m_pc, m_valid, m_count, m_halted); end
        end
    endtask

    task automatic test_reset_in_halt();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h0 || halted !== 1'b0 || fetch_count !== 32'h0 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL halt_reset: got addr=%h h=%b cnt=%0d v=%b expected 0/0/0/0", imem_addr, halted, fetch_count, ifid_valid); end
    endtask

    task automatic test_halt_cancel();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 32'h48) begin
            errors++; $display("FAIL cancel_flush: got h=%b v=%b addr=%h expected 0/0/48", halted, ifid_valid, imem_addr); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 32'h48) begin
            errors++; $display("FAIL cancel_run: got h=%b v=%b pc=%h expected 0/1/48", halted, ifid_valid, ifid_pc); end
    endtask

    task automatic test_random();
        logic rst_n, st, fl, rd;
        logic [31:0] rpc;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(99) >= 3);
            st    = ($urandom_range(99) < 25);
            fl    = ($urandom_range(99) < 15);
            rd    = ($urandom_range(99) < 15);
            rpc   = {($urandom_range(3) == 0) ? 22'($urandom) : 22'd0, 8'($urandom_range(255)), 2'b00};
            cycle(rst_n, st, fl, rd, rpc);
            checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, imem_addr, m_pc); end
            checks++; if (ifid_pc !== m_ifid_pc || ifid_pc4 !== m_ifid_pc4) begin errors++; $display("FAIL rnd_ifid_pc[%0d]: got %h/%h expected %h/%h", n, ifid_pc, ifid_pc4, m_ifid_pc, m_ifid_pc4); end
            checks++; if (ifid_instr !== m_ifid_instr || ifid_valid !== m_valid) begin errors++; $display("FAIL rnd_ifid_instr[%0d]: got %h v=%b expected %h v=%b", n, ifid_instr, ifid_valid, m_ifid_instr, m_valid); end
            checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, fetch_count, m_count); end
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted[%0d]: got %b expected %b", n, halted, m_halted); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            if (rom[i][31:26] == 6'b000010 || rom[i] == 32'h1000_FFFF) rom[i][31:26] = 6'b000000;
        end
        rom[16] = 32'h0800_0010;
        rom[32] = 32'h1000_FFFF;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_reset_in_halt();
        test_halt_cancel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller for the 5-stage MIPS pipeline. It owns the PC, drives the address of the combinational instruction memory, and loads the IF/ID pipeline register. It also applies stall, branch/jump redirect and flush requests from the hazard/ID logic. Optionally it detects a self-loop "program end" instruction and parks the fetch stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; overrides every other input.
- `stall`  in  1  hold PC and IF/ID (load-use hazard).
- `redirect`  in  1  load PC from `redirect_pc` (branch taken / j / jal / jr resolved in ID).
- `redirect_pc`  in  32  redirect target.
- `flush`  in  1  load a bubble into IF/ID this cycle.
- `imem_addr`  out  32  instruction memory address; equals the PC register (combinational from it).
- `imem_instr`  in  32  instruction word returned combinationally for `imem_addr`.
- `ifid_pc`  out  32  PC of the instruction held in IF/ID.
- `ifid_pc4`  out  32  `ifid_pc + 4`, registered.
- `ifid_instr`  out  32  instruction held in IF/ID; 0 (nop) when bubble.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch parked on self-loop.
- `fetch_count`  out  32  number of valid instructions captured into IF/ID.

## Operation
- Reset values: PC = `RESET_PC`; `ifid_pc`, `ifid_pc4`, `ifid_instr`, `fetch_count` = 0; `ifid_valid` = 0; `halted` = 0; FSM = RUN.
- Priority each cycle, after reset: HALT state > stall > flush/redirect > normal advance.
- Normal advance (RUN/PEND, stall=0):
  - IF/ID <= {PC, PC+4, `imem_instr`, valid=1}.
  - PC <= PC+4, or `redirect_pc` if `redirect`=1.
  - `fetch_count` += 1.
- Delay slot: `redirect` does not discard the instruction being fetched in the same cycle. That instruction is the delay slot and is captured normally.
- `flush`=1, stall=0: IF/ID <= {0, 0, 0, valid=0}; the PC still advances or redirects; count not incremented.
- `stall`=1:
  - PC, IF/ID and count hold, including when `flush` is also high.
  - `redirect` is ignored while stalled. The requester holds `redirect`/`redirect_pc` until stall drops.
- Arithmetic: PC+4 wraps modulo 2^32. The memory indexes only `Address[9:2]`, so addresses beyond 0x3FC alias; the controller does not range-check.
- FSM (with halt detect):
  - RUN -> PEND when a self-loop instruction is captured with valid=1. Self-loop means either:
    - `j` with opcode 000010 and {PC[31:28], target, 2'b00} == PC, or
    - 32'h1000FFFF (`beq $0,$0,-1`).
  - PEND -> RUN if `flush` or `redirect` is seen while stall=0. The loop was on a squashed or redirected path.
  - PEND -> HALT on any other non-stalled cycle. PEND holds while stall=1.
  - HALT:
    - PC frozen.
    - IF/ID loads a bubble every cycle.
    - `halted`=1, count frozen.
    - `stall`/`redirect`/`flush` ignored; exit only via reset.
- Counter `fetch_count` wraps modulo 2^32.

## Timing
- Fetch latency: instruction at address A appears in IF/ID one cycle after the PC equals A.
- First valid instruction: `ifid_valid`=1 in the first cycle after the cycle where `reset`=1 is first sampled.
- Redirect asserted in cycle n (unstalled): `imem_addr` = `redirect_pc` in cycle n+1. The target instruction is in IF/ID in cycle n+2.
- Halt: self-loop captured at edge k gives PEND in cycle k. If PEND is not cancelled, `halted`=1 and the FSM is in HALT after edge k+1.
- Reset is asserted synchronously mid-operation in any state, including HALT. All reset values are present after that edge.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - PEND/HALT states and self-loop decode are built.
  - `halted` is live.
- Not defined:
  - FSM is permanently RUN and `halted` is tied 0.
  - Self-loops are fetched forever and `fetch_count` keeps incrementing.

## Test plan
- Reset, then run 4 cycles against a ROM model -> `ifid_pc` = 0, 4, 8, 0xC; `ifid_pc4` = 4, 8, 0xC, 0x10; `fetch_count` = 4.
- `stall`=1 for 2 cycles, with `flush` also high in the second cycle -> `imem_addr`, IF/ID and count unchanged for both cycles. Normal advance resumes after stall drops.
- `redirect`=1 with `redirect_pc`=0x48 while the PC is 0x3C (the `jal` is in IF/ID at 0x38) -> next captured pc 0x3C (delay slot), then 0x48.
- `flush` pulse for 1 cycle -> `ifid_valid`=0 and `ifid_instr`=0 for that cycle; PC still advances by 4; count not incremented.
- Word 32'h08000010 at address 0x40 -> PEND, then `halted`=1 one cycle later; IF/ID stays a bubble and `imem_addr` stays 0x44. Repeat with `flush` in the PEND cycle -> back to RUN, `halted` stays 0.
- `reset`=0 for 1 cycle while in HALT -> after the edge, PC=0, `halted`=0, `fetch_count`=0, `ifid_valid`=0.
